// File: rtl/mux_rr_arbiter_pkg.sv
// ============================================================================
// Module      : mux_arb_pkg
// Description : Shared constants and FSM state type for the round-robin mux
//               arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mux_arb_pkg;

    localparam int NUM_REQ = 4;
    localparam int SEL_W   = 2;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

endpackage

`default_nettype wire

// File: rtl/mux_rr_arbiter_if.sv
// ============================================================================
// Module      : mux_rr_arbiter_if
// Description : Requester / output-port bundle of the round-robin mux arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mux_rr_arbiter_if #(
    parameter int WIDTH = 4
);
    import mux_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [WIDTH-1:0]   in0;
    logic [WIDTH-1:0]   in1;
    logic [WIDTH-1:0]   in2;
    logic [WIDTH-1:0]   in3;
    logic               out_ready;
    logic [NUM_REQ-1:0] grant;
    logic [SEL_W-1:0]   sel;
    logic [WIDTH-1:0]   out;
    logic               out_valid;

    // master: requesters plus downstream consumer; slave: the arbiter
    modport master (
        output req, in0, in1, in2, in3, out_ready,
        input  grant, sel, out, out_valid
    );

    modport slave (
        input  req, in0, in1, in2, in3, out_ready,
        output grant, sel, out, out_valid
    );

endinterface

`default_nettype wire

// File: rtl/mux_rr_arbiter_rr_pick.sv
// ============================================================================
// Module      : rr_pick
// Description : Combinational round-robin picker: first set request searching
//               upward from last+1 with wrap.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_REQ-1:0] req,
    input  logic [SEL_W-1:0]   last,
    output logic               any,
    output logic [SEL_W-1:0]   idx,
    output logic [NUM_REQ-1:0] onehot
);

    logic [SEL_W-1:0] w_cand;

    // Scan from lowest priority (last) to highest (last+1) so the final hit wins.
    always_comb begin
        any    = |req;
        idx    = '0;
        onehot = '0;
        w_cand = '0;
        for (int k = NUM_REQ; k >= 1; k--) begin
            w_cand = last + SEL_W'(k);
            if (req[w_cand]) begin
                idx = w_cand;
            end
        end
        if (any) begin
            onehot[idx] = 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/mux_rr_arbiter.sv
// ============================================================================
// Module      : mux_rr_arbiter
// Description : Round-robin arbiter owning the select of a shared 4:1 data mux
//               with a valid/ready output. Optional MUX_ARB_TIMEOUT_EN adds a
//               per-grant transfer limit (HOLD_MAX) while others wait.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mux_rr_arbiter
    import mux_arb_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int HOLD_MAX = 8
) (
    input  logic             clk,
    input  logic             rst,
    mux_rr_arbiter_if.slave  bus
);

    arb_state_t          r_state;
    logic [SEL_W-1:0]    r_last;
    logic [SEL_W-1:0]    r_sel;
    logic [NUM_REQ-1:0]  r_grant;
    logic                r_valid;

    logic                w_any;
    logic [SEL_W-1:0]    w_idx;
    logic [NUM_REQ-1:0]  w_onehot;
    logic                w_preempt;
    logic                w_release;
    logic [WIDTH-1:0]    w_data;

    rr_pick u_rr_pick (
        .req    (bus.req),
        .last   (r_last),
        .any    (w_any),
        .idx    (w_idx),
        .onehot (w_onehot)
    );

`ifdef MUX_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(HOLD_MAX + 1);
    localparam logic [CNT_W-1:0] c_hold_max = CNT_W'(HOLD_MAX);

    logic             w_transfer;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [CNT_W-1:0] w_hold_next;

    assign w_transfer = r_valid & bus.out_ready;

    // Counter saturates at HOLD_MAX so a lone requester keeps its grant.
    always_comb begin
        w_hold_next = r_hold_cnt;
        if (w_transfer && (r_hold_cnt != c_hold_max)) begin
            w_hold_next = r_hold_cnt + CNT_W'(1);
        end
        w_preempt = w_transfer && (w_hold_next == c_hold_max) &&
                    (|(bus.req & ~r_grant));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_hold_cnt <= '0;
        end else if (r_state == IDLE) begin
            r_hold_cnt <= '0;
        end else begin
            r_hold_cnt <= w_hold_next;
        end
    end
`else
    assign w_preempt = 1'b0;
`endif

    assign w_release = ~bus.req[r_sel] | w_preempt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
            r_last  <= SEL_W'(NUM_REQ - 1);
            r_sel   <= '0;
            r_grant <= '0;
            r_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_any) begin
                        r_grant <= w_onehot;
                        r_sel   <= w_idx;
                        r_last  <= w_idx;
                        r_valid <= 1'b1;
                        r_state <= GRANT;
                    end
                end
                GRANT: begin
                    if (w_release) begin
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_state <= IDLE;
                    end
                end
                default: begin
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    always_comb begin
        w_data = '0;
        case (r_sel)
            2'd0:    w_data = bus.in0;
            2'd1:    w_data = bus.in1;
            2'd2:    w_data = bus.in2;
            default: w_data = bus.in3;
        endcase
    end

    assign bus.grant     = r_grant;
    assign bus.sel       = r_sel;
    assign bus.out_valid = r_valid;
    assign bus.out       = r_valid ? w_data : '0;

endmodule

`default_nettype wire
